uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default divisor,
// frame constants and a 2-of-3 vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } state_t;

  localparam int   DEFAULT_DIV = 434;
  localparam int   DATA_BITS   = 8;
  localparam logic STOP_LEVEL  = 1'b1;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1
// so an idle-high line does not look like activity straight after reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, DIV clocks per bit, mid-bit sampling, byte held
// until the consumer handshakes it.
// Build option: UART_RX_MAJORITY_EN -- when defined, every start/data/stop
// decision is a 2-of-3 vote of the samples at counter values 2, 1 and 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] LP_RELOAD = 16'(DIV - 1);
  localparam logic [15:0] LP_HALF   = 16'(DIV / 2 - 1);
  localparam logic [2:0]  LP_LAST   = 3'(DATA_BITS - 1);

  logic        w_rx_s;
  logic        w_bit;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic r_samp2;
  logic r_samp1;

  // Capture the two early votes just before each decision point
  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp2 <= 1'b1;
      r_samp1 <= 1'b1;
    end else begin
      if (r_cnt == 16'd2) r_samp2 <= w_rx_s;
      if (r_cnt == 16'd1) r_samp1 <= w_rx_s;
    end
  end

  assign w_bit = maj3(r_samp2, r_samp1, w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  // Receive FSM with registered data/valid/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_valid && out_ready) r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= LP_HALF;
          end
        end
        ST_START: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!w_bit) begin
            r_state <= ST_DATA;
            r_idx   <= 3'd0;
            r_cnt   <= LP_RELOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_shift <= {w_bit, r_shift[7:1]};
            r_cnt   <= LP_RELOAD;
            if (r_idx == LP_LAST) r_state <= ST_STOP;
            else                  r_idx   <= r_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (w_bit == STOP_LEVEL) begin
            // A load wins over the handshake clear above
            r_state   <= ST_IDLE;
            r_data    <= r_shift;
            r_valid   <= 1'b1;
            r_overrun <= r_valid && !out_ready;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          // Hold off until the line recovers so a break cannot retrigger
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign out_valid = r_valid;
  assign busy      = (r_state != ST_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=16: directed frames, false starts,
// framing error, overrun, reset mid-frame, glitch rejection and random bytes.
module tb_uart_rx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start   = 0;
  int last_rise = -1;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_busy = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: collect handshaken bytes and pulse counts
  always @(negedge clk) begin
    if (out_valid && out_ready) rx_q.push_back(data);
    if (out_valid && !prev_valid) last_rise = cyc;
    prev_valid = out_valid;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (busy) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serialize one 8N1 frame; optional 1-clock glitch in the middle of a data bit.
  // The line is left at stop_val afterwards.
  task automatic send(input logic [7:0] b, input logic stop_val, input int glitch_bit);
    @(posedge clk);
    #1;
    t_start = cyc;
    rxd = 1'b0;
    wait_clk(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == glitch_bit) begin
        wait_clk(DIV / 2);
        rxd = ~b[i];
        wait_clk(1);
        rxd = b[i];
        wait_clk(DIV - DIV / 2 - 1);
      end else begin
        wait_clk(DIV);
      end
    end
    rxd = stop_val;
    wait_clk(DIV);
  endtask

  function automatic logic [8:0] pop_rx();
    if (rx_q.size() == 0) return 9'h1FF;
    return {1'b0, rx_q.pop_front()};
  endfunction

  initial begin
    int f0;
    int b0;
    logic [7:0] r;

    rxd = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    wait_clk(4);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(data), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    wait_clk(4);

    // Basic frame 0x55 with latency: 2 sync + 1 detect + DIV/2 + 9 bit times
    send(8'h55, 1'b1, -1);
    wait_clk(4);
    check("b55_count", 32'(rx_q.size()), 1);
    check("b55_data", 32'(pop_rx()), 32'h55);
    check("b55_latency", 32'(last_rise - t_start), 32'(3 + DIV / 2 + 9 * DIV));
    check("b55_ferr", 32'(n_ferr), 0);
    check("b55_ovr", 32'(n_ovr), 0);

    // False starts: low pulses shorter than half a bit
    b0 = n_busy;
    rxd = 1'b0;
    wait_clk(5);
    rxd = 1'b1;
    wait_clk(3 * DIV);
    check("fs5_busyrose", 32'(n_busy > b0), 1);
    check("fs5_busy", 32'(busy), 0);
    rxd = 1'b0;
    wait_clk(DIV / 2 - 1);
    rxd = 1'b1;
    wait_clk(3 * DIV);
    check("fs7_none", 32'(rx_q.size()), 0);
    check("fs_ferr", 32'(n_ferr), 0);

    // Framing error followed by a break, then a good byte
    send(8'h3C, 1'b0, -1);
    wait_clk(40);
    check("fe_count", 32'(n_ferr), 1);
    check("fe_valid", 32'(out_valid), 0);
    check("fe_waithi", 32'(busy), 1);
    rxd = 1'b1;
    wait_clk(4);
    check("fe_idle", 32'(busy), 0);
    send(8'h81, 1'b1, -1);
    wait_clk(4);
    check("b81_data", 32'(pop_rx()), 32'h81);
    check("b81_ferr", 32'(n_ferr), 1);

    // Overrun with the consumer stalled
    out_ready = 1'b0;
    send(8'h11, 1'b1, -1);
    wait_clk(4);
    check("ov_valid1", 32'(out_valid), 1);
    check("ov_data1", 32'(data), 32'h11);
    check("ov_none", 32'(n_ovr), 0);
    send(8'h22, 1'b1, -1);
    wait_clk(4);
    check("ov_count", 32'(n_ovr), 1);
    check("ov_data2", 32'(data), 32'h22);

    // Reset in the middle of the next frame's data bits
    @(posedge clk);
    #1;
    rxd = 1'b0;
    wait_clk(DIV);
    rxd = 1'b1;
    wait_clk(DIV);
    rxd = 1'b0;
    wait_clk(DIV / 2);
    check("mr_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    rxd = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("mr_valid", 32'(out_valid), 0);
    check("mr_data", 32'(data), 0);
    check("mr_busy", 32'(busy), 0);
    f0 = n_ferr;
    wait_clk(12 * DIV);
    check("mr_quiet_v", 32'(out_valid), 0);
    check("mr_quiet_fe", 32'(n_ferr - f0), 0);
    out_ready = 1'b1;
    wait_clk(2);
    rx_q.delete();
    r = 8'($urandom_range(0, 255));
    send(r, 1'b1, -1);
    wait_clk(4);
    check("mr_rearm", 32'(pop_rx()), 32'(r));

    // One-clock glitch at the sampling instant of data bit 3
    send(8'h00, 1'b1, 3);
    wait_clk(4);
`ifdef UART_RX_MAJORITY_EN
    check("glitch", 32'(pop_rx()), 32'h00);
`else
    check("glitch", 32'(pop_rx()), 32'h08);
`endif

    // Random bytes back-to-back, checked against the sent-order queue
    rx_q.delete();
    exp_q.delete();
    f0 = n_ferr;
    b0 = n_ovr;
    for (int k = 0; k < 8; k++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back(r);
      send(r, 1'b1, -1);
    end
    wait_clk(2 * DIV);
    check("rnd_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rnd_%0d", k), 32'(pop_rx()), 32'(exp_q[k]));
    end
    check("rnd_ferr", 32'(n_ferr - f0), 0);
    check("rnd_ovr", 32'(n_ovr - b0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
